reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  - 32-entry integer register file for the RISC-V core (x0..x31): two combinational read ports, one clocked write port.
//  - Read ports feed decode/execute operands (rs1, rs2); write port takes writeback result (rd).
//  - x0 is architecturally hardwired to zero.
// PARAMETERS
//  - ADDR_WIDTH  5   register select width; depth = 2**ADDR_WIDTH (32)
//  - DATA_WIDTH  32  register/data width (XLEN)
// PORTS
//  - CLK        in   1           single clock; all state updates on rising edge
//  - RESET      in   1           reset, synchronous, active-high
//  - WEN        in   1           write enable for writeback
//  - RS1_SEL    in   ADDR_WIDTH  read port 1 register index
//  - RS2_SEL    in   ADDR_WIDTH  read port 2 register index
//  - RD_SEL     in   ADDR_WIDTH  write register index
//  - WB_DATA    in   DATA_WIDTH  write data
//  - SRC1_DOUT  out  DATA_WIDTH  contents of register RS1_SEL
//  - SRC2_DOUT  out  DATA_WIDTH  contents of register RS2_SEL
// BEHAVIOUR
//  - Reset: on rising CLK with RESET=1, all 32 registers become 0.
//    - RESET has priority over WEN; a pending write in that cycle is dropped.
//    - Outputs read 0 for every select after the reset edge.
//  - Write: on rising CLK with RESET=0, WEN=1, RD_SEL!=0, reg[RD_SEL] <= WB_DATA.
//    - WEN=0: no register changes.
//  - x0: writes with RD_SEL=0 are ignored regardless of WB_DATA. Any read of index 0 returns 0.
//  - Read: SRC1_DOUT/SRC2_DOUT are purely combinational from RS*_SEL and current register state, with zero-cycle latency.
//    - Select change is reflected in the same cycle.
//    - A write becomes visible on the read ports immediately after the writing edge.
//  - No internal write-to-read bypass: a same-cycle read of RD_SEL before the edge returns the old value. Forwarding is the pipeline's job.
//  - Both read ports are independent and may select the same register, including RD_SEL. Each returns identical data.
//  - No handshake and no stall; a write is accepted every cycle WEN=1.
//  - Reset mid-sequence: all prior writes are lost and registers return to 0. Normal writes resume on the first edge with RESET=0.
//  - Before the first reset, register contents are undefined except x0, which reads 0.
// STRUCTURE
//  - Storage: array reg [DATA_WIDTH-1:0] regs [0:2**ADDR_WIDTH-1], one always @(posedge CLK) for reset/write.
//  - Read muxes: continuous assigns with the x0 zero check.
//  - Shared package holds XLEN=32, REG_ADDR_W=5, NUM_REGS=32 and the ZERO_REG=0 index constant, reused by decode/hazard logic.
//  - No sub-module needed; the read port is optionally a small reg_file_rd_port mux sub-module instantiated twice.
// TESTING
//  1. Hold RESET=1 for 10 cycles, then sweep RS1/RS2 over all 32 indices -> every read = 0.
//  2. Release reset; for i=0..31, one cycle each, WEN=1, RD_SEL=i, WB_DATA=i*13, then WEN=0.
//     -> reg i reads i*13 for i>=1 (x1=13, x5=65, x31=403); x0 reads 0.
//  3. Read sweep j=0..14 with RS1_SEL=j, RS2_SEL=31-j -> SRC1=j*13 (0 for j=0), SRC2=(31-j)*13.
//     - Examples: j=3 gives 39/364; j=14 gives 182/221.
//     - Each output updates in the same cycle as its select.
//  4. WEN=1, RD_SEL=0, WB_DATA=23, then 50, then 73 on consecutive cycles -> SRC1/SRC2 with select 0 stay 0; x1..x31 unchanged.
//  5. Same cycle: WEN=1, RD_SEL=7, WB_DATA=0xDEADBEEF, RS1_SEL=RS2_SEL=7.
//     -> before the edge both read 91 (7*13); after the edge both read 0xDEADBEEF.
//  6. RESET=1 together with WEN=1, RD_SEL=9, WB_DATA=0x55 -> after the edge x9=0 and all registers=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
//   Shared constants for the integer register file. Decode and hazard logic
//   import the same package so register indices and widths stay consistent.
//   XLEN       : integer register / datapath width
//   REG_ADDR_W : register index width
//   NUM_REGS   : number of architectural integer registers
//   ZERO_REG   : index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package reg_file_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;
    localparam int ZERO_REG   = 0;
endpackage : reg_file_pkg

// File: rtl/reg_file_rd_port.sv
// ---------------------------------------------------------------------------
// reg_file_rd_port
//   One combinational read port. Selects an entry from the flattened register
//   array and forces index x0 to zero, so x0 reads 0 even before the first
//   reset has cleared the storage.
//   regs_i : all register contents, entry n at regs_i[n]
//   sel_i  : register index to read
//   data_o : contents of register sel_i (0 when sel_i selects x0)
// ---------------------------------------------------------------------------
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs_i,
    input  logic [ADDR_WIDTH-1:0]                    sel_i,
    output logic [DATA_WIDTH-1:0]                    data_o
);
    assign data_o = (sel_i == ADDR_WIDTH'(ZERO_REG)) ? '0 : regs_i[sel_i];
endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
//   32-entry integer register file: two combinational read ports (rs1, rs2)
//   and one clocked write port (rd). x0 is hardwired to zero. No write-to-read
//   bypass: a read in the writing cycle returns the old value; forwarding is
//   done by the pipeline.
//   CLK       : clock, all state updates on the rising edge
//   RESET     : synchronous active-high reset, clears all registers, beats WEN
//   WEN       : writeback enable
//   RS1_SEL   : read port 1 index      -> SRC1_DOUT
//   RS2_SEL   : read port 2 index      -> SRC2_DOUT
//   RD_SEL    : write index (x0 writes are discarded)
//   WB_DATA   : write data
// ---------------------------------------------------------------------------
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DATA_WIDTH = XLEN
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WEN,
    input  logic [ADDR_WIDTH-1:0] RS1_SEL,
    input  logic [ADDR_WIDTH-1:0] RS2_SEL,
    input  logic [ADDR_WIDTH-1:0] RD_SEL,
    input  logic [DATA_WIDTH-1:0] WB_DATA,
    output logic [DATA_WIDTH-1:0] SRC1_DOUT,
    output logic [DATA_WIDTH-1:0] SRC2_DOUT
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic                             wr_en;

    // x0 is never written, so its storage only ever holds the reset value.
    assign wr_en = WEN && (RD_SEL != ADDR_WIDTH'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[RD_SEL] = WB_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_file_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port1 (
        .regs_i (regs_q),
        .sel_i  (RS1_SEL),
        .data_o (SRC1_DOUT)
    );

    reg_file_rd_port #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rd_port2 (
        .regs_i (regs_q),
        .sel_i  (RS2_SEL),
        .data_o (SRC2_DOUT)
    );
endmodule : reg_file

// File: tb/tb_reg_file.sv
// ---------------------------------------------------------------------------
// tb_reg_file
//   Directed bench for reg_file with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic        wen;
    logic [4:0]  rs1_sel;
    logic [4:0]  rs2_sel;
    logic [4:0]  rd_sel;
    logic [31:0] wb_data;
    logic [31:0] src1;
    logic [31:0] src2;

    int checks   = 0;
    int failures = 0;

    reg_file dut (
        .CLK       (clk),
        .RESET     (rst),
        .WEN       (wen),
        .RS1_SEL   (rs1_sel),
        .RS2_SEL   (rs2_sel),
        .RD_SEL    (rd_sel),
        .WB_DATA   (wb_data),
        .SRC1_DOUT (src1),
        .SRC2_DOUT (src2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Advance one rising edge; inputs change 1 ns after it, reads 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] val13(input int i);
        return (i == 0) ? 32'd0 : 32'(i * 13);
    endfunction

    initial begin
        rst     = 1'b1;
        wen     = 1'b0;
        rs1_sel = '0;
        rs2_sel = '0;
        rd_sel  = '0;
        wb_data = '0;

        // 1. reset held for 10 cycles, every register reads 0
        repeat (10) tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_sel = 5'(i);
            rs2_sel = 5'(31 - i);
            #1;
            chk($sformatf("rst_rs1[%0d]", i), src1, 32'd0);
            chk($sformatf("rst_rs2[%0d]", 31 - i), src2, 32'd0);
        end

        // 2. write i*13 into every register, x0 write dropped
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            wen     = 1'b1;
            rd_sel  = 5'(i);
            wb_data = 32'(i * 13);
            tick();
        end
        wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_sel = 5'(i);
            rs2_sel = 5'(i);
            #1;
            chk($sformatf("wr_rs1[%0d]", i), src1, val13(i));
            chk($sformatf("wr_rs2[%0d]", i), src2, val13(i));
        end
        rs1_sel = 5'd1;  #1; chk("x1_is_13", src1, 32'd13);
        rs1_sel = 5'd5;  #1; chk("x5_is_65", src1, 32'd65);
        rs1_sel = 5'd31; #1; chk("x31_is_403", src1, 32'd403);

        // 3. crossed read sweep, outputs follow selects with no clock edge
        for (int j = 0; j <= 14; j++) begin
            rs1_sel = 5'(j);
            rs2_sel = 5'(31 - j);
            #1;
            chk($sformatf("sweep_src1[%0d]", j), src1, val13(j));
            chk($sformatf("sweep_src2[%0d]", j), src2, 32'((31 - j) * 13));
        end
        rs1_sel = 5'd3;  rs2_sel = 5'd28; #1;
        chk("j3_src1", src1, 32'd39);
        chk("j3_src2", src2, 32'd364);
        rs1_sel = 5'd14; rs2_sel = 5'd17; #1;
        chk("j14_src1", src1, 32'd182);
        chk("j14_src2", src2, 32'd221);

        // 4. back-to-back writes to x0 are ignored
        @(posedge clk);
        #1;
        rs1_sel = 5'd0;
        rs2_sel = 5'd0;
        wen     = 1'b1;
        rd_sel  = 5'd0;
        wb_data = 32'd23; tick();
        chk("x0_w23_src1", src1, 32'd0);
        chk("x0_w23_src2", src2, 32'd0);
        wb_data = 32'd50; tick();
        chk("x0_w50_src1", src1, 32'd0);
        wb_data = 32'd73; tick();
        chk("x0_w73_src1", src1, 32'd0);
        chk("x0_w73_src2", src2, 32'd0);
        wen = 1'b0;
        for (int i = 1; i < 32; i++) begin
            rs1_sel = 5'(i);
            rs2_sel = 5'(i);
            #1;
            chk($sformatf("x0wr_keep_rs1[%0d]", i), src1, val13(i));
            chk($sformatf("x0wr_keep_rs2[%0d]", i), src2, val13(i));
        end

        // WEN=0 with a live-looking write must not change anything
        @(posedge clk);
        #1;
        wen     = 1'b0;
        rd_sel  = 5'd3;
        wb_data = 32'hCAFE_F00D;
        rs1_sel = 5'd3;
        tick();
        chk("wen0_x3_kept", src1, 32'd39);

        // 5. same-cycle read of the write target returns the old value
        wen     = 1'b1;
        rd_sel  = 5'd7;
        wb_data = 32'hDEAD_BEEF;
        rs1_sel = 5'd7;
        rs2_sel = 5'd7;
        #1;
        chk("x7_pre_src1", src1, 32'd91);
        chk("x7_pre_src2", src2, 32'd91);
        tick();
        wen = 1'b0;
        chk("x7_post_src1", src1, 32'hDEAD_BEEF);
        chk("x7_post_src2", src2, 32'hDEAD_BEEF);

        // 6. reset beats a coincident write and clears everything
        rst     = 1'b1;
        wen     = 1'b1;
        rd_sel  = 5'd9;
        wb_data = 32'h55;
        rs1_sel = 5'd9;
        #1;
        chk("x9_pre_rst", src1, 32'd117);
        tick();
        rst = 1'b0;
        wen = 1'b0;
        chk("x9_after_rst", src1, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rs1_sel = 5'(i);
            rs2_sel = 5'(31 - i);
            #1;
            chk($sformatf("rst2_rs1[%0d]", i), src1, 32'd0);
            chk($sformatf("rst2_rs2[%0d]", 31 - i), src2, 32'd0);
        end

        // writes resume on the first edge after reset is released
        @(posedge clk);
        #1;
        wen     = 1'b1;
        rd_sel  = 5'd9;
        wb_data = 32'h1234_5678;
        rs1_sel = 5'd9;
        rs2_sel = 5'd10;
        tick();
        wen = 1'b0;
        chk("resume_x9", src1, 32'h1234_5678);
        chk("resume_x10", src2, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_reg_file
